// File: rtl/mgm_sequencer.sv
// Packs an A/M byte stream into 64-bit MSB-first blocks and drives the mgm command sequence.
// Optional WAIT watchdog: define MGM_SEQ_TIMEOUT_EN to abort a frame after 255 idle WAIT cycles.

`ifndef CMD_NONE
`define CMD_NONE     6'd0
`endif
`ifndef CMD_START_A
`define CMD_START_A  6'd1
`endif
`ifndef CMD_A
`define CMD_A        6'd2
`endif
`ifndef CMD_FIN_A
`define CMD_FIN_A    6'd3
`endif
`ifndef CMD_START_M
`define CMD_START_M  6'd4
`endif
`ifndef CMD_DOUBLE_M
`define CMD_DOUBLE_M 6'd5
`endif
`ifndef CMD_FIN_M
`define CMD_FIN_M    6'd6
`endif
`ifndef CMD_FIN
`define CMD_FIN      6'd7
`endif

module mgm_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    input  logic        s_type,
    input  logic        s_last,
    output logic [5:0]  cmd,
    output logic [63:0] blk,
    output logic [63:0] blen,
    input  logic        done,
    input  logic [63:0] C,
    input  logic [63:0] T,
    output logic        c_valid,
    output logic [63:0] c_data,
    output logic [3:0]  c_bytes,
    output logic        tag_valid,
    output logic [63:0] tag,
    output logic        busy,
    output logic        err
);

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_START_A = 4'd1;
    localparam logic [3:0] ST_COL_A   = 4'd2;
    localparam logic [3:0] ST_ISS_A   = 4'd3;
    localparam logic [3:0] ST_START_M = 4'd4;
    localparam logic [3:0] ST_COL_M   = 4'd5;
    localparam logic [3:0] ST_ISS_M   = 4'd6;
    localparam logic [3:0] ST_FIN     = 4'd7;
    localparam logic [3:0] ST_WAIT    = 4'd8;

    function automatic logic [63:0] packByte(input logic [63:0] blkIn,
                                             input logic [3:0]  idx,
                                             input logic [7:0]  b);
        packByte = blkIn | ({b, 56'h0} >> {idx, 3'b000});
    endfunction

    function automatic logic [63:0] bitLen(input logic [3:0] nBytes);
        bitLen = {57'd0, nBytes, 3'b000};
    endfunction

    function automatic logic [63:0] byteMask(input logic [3:0] nBytes);
        byteMask = ~(64'hFFFF_FFFF_FFFF_FFFF >> {nBytes, 3'b000});
    endfunction

    logic [3:0]  state_q, state_d;
    logic [63:0] colBuf_q, colBuf_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        heldLast_q, heldLast_d;
    logic        fin_q, fin_d;
    logic [5:0]  lastCmd_q, lastCmd_d;
    logic [63:0] blk_q, blk_d;
    logic [63:0] blen_q, blen_d;
    logic [3:0]  issBytes_q, issBytes_d;
    logic        err_q, err_d;
    logic        cValid_q, cValid_d;
    logic [63:0] cData_q, cData_d;
    logic [3:0]  cBytes_q, cBytes_d;
    logic        tagValid_q, tagValid_d;
    logic [63:0] tag_q, tag_d;
    logic        doneD_q;
    logic        readyEn_q;
`ifdef MGM_SEQ_TIMEOUT_EN
    logic [7:0]  toCnt_q, toCnt_d;
`endif

    logic        accept;
    logic        doneEdge;
    logic        colIsM;
    logic [63:0] merged;
    logic [3:0]  cntNext;

    // readyEn_q keeps s_ready low until the first clock after reset release
    assign s_ready   = readyEn_q & ((state_q == ST_IDLE) || (state_q == ST_COL_A) || (state_q == ST_COL_M));
    assign busy      = (state_q != ST_IDLE);
    assign accept    = s_valid & s_ready;
    assign doneEdge  = done & ~doneD_q;
    assign colIsM    = (state_q == ST_COL_M);
    assign merged    = packByte(colBuf_q, cnt_q, s_data);
    assign cntNext   = cnt_q + 4'd1;

    assign blk       = blk_q;
    assign blen      = blen_q;
    assign err       = err_q;
    assign c_valid   = cValid_q;
    assign c_data    = cData_q;
    assign c_bytes   = cBytes_q;
    assign tag_valid = tagValid_q;
    assign tag       = tag_q;

    always_comb begin
        state_d    = state_q;
        colBuf_d   = colBuf_q;
        cnt_d      = cnt_q;
        heldLast_d = heldLast_q;
        fin_d      = fin_q;
        lastCmd_d  = lastCmd_q;
        blk_d      = blk_q;
        blen_d     = blen_q;
        issBytes_d = issBytes_q;
        err_d      = err_q;
        cValid_d   = 1'b0;
        cData_d    = cData_q;
        cBytes_d   = cBytes_q;
        tagValid_d = 1'b0;
        tag_d      = tag_q;
        cmd        = `CMD_NONE;
`ifdef MGM_SEQ_TIMEOUT_EN
        toCnt_d    = 8'd0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (s_type) begin
                        err_d = 1'b1;
                    end else begin
                        colBuf_d   = packByte(64'h0, 4'd0, s_data);
                        cnt_d      = 4'd1;
                        heldLast_d = s_last;
                        blk_d      = 64'h0;
                        blen_d     = 64'h0;
                        state_d    = ST_START_A;
                    end
                end
            end

            ST_COL_A, ST_COL_M: begin
                if (accept) begin
                    if (s_type != colIsM) begin
                        err_d = 1'b1;
                    end else if (cnt_q == 4'd7 || s_last) begin
                        blk_d      = merged;
                        blen_d     = bitLen(cntNext);
                        issBytes_d = cntNext;
                        fin_d      = s_last;
                        colBuf_d   = 64'h0;
                        cnt_d      = 4'd0;
                        state_d    = colIsM ? ST_ISS_M : ST_ISS_A;
                    end else begin
                        colBuf_d = merged;
                        cnt_d    = cntNext;
                    end
                end
            end

            ST_START_A: begin
                cmd     = `CMD_START_A;
                state_d = ST_WAIT;
            end

            ST_ISS_A: begin
                cmd     = fin_q ? `CMD_FIN_A : `CMD_A;
                state_d = ST_WAIT;
            end

            ST_START_M: begin
                cmd     = `CMD_START_M;
                state_d = ST_WAIT;
            end

            ST_ISS_M: begin
                cmd     = fin_q ? `CMD_FIN_M : `CMD_DOUBLE_M;
                state_d = ST_WAIT;
            end

            ST_FIN: begin
                cmd     = `CMD_FIN;
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                if (doneEdge) begin
                    case (lastCmd_q)
                        `CMD_START_A: begin
                            // A one-byte A segment is already complete in the held byte
                            if (heldLast_q) begin
                                blk_d      = colBuf_q;
                                blen_d     = bitLen(cnt_q);
                                issBytes_d = cnt_q;
                                fin_d      = 1'b1;
                                colBuf_d   = 64'h0;
                                cnt_d      = 4'd0;
                                state_d    = ST_ISS_A;
                            end else begin
                                state_d = ST_COL_A;
                            end
                        end
                        `CMD_A:       state_d = ST_COL_A;
                        `CMD_FIN_A: begin
                            blk_d   = 64'h0;
                            blen_d  = 64'h0;
                            state_d = ST_START_M;
                        end
                        `CMD_START_M: state_d = ST_COL_M;
                        `CMD_DOUBLE_M: begin
                            cValid_d = 1'b1;
                            cData_d  = C & byteMask(issBytes_q);
                            cBytes_d = issBytes_q;
                            state_d  = ST_COL_M;
                        end
                        `CMD_FIN_M: begin
                            cValid_d = 1'b1;
                            cData_d  = C & byteMask(issBytes_q);
                            cBytes_d = issBytes_q;
                            blk_d    = 64'h0;
                            blen_d   = 64'h0;
                            state_d  = ST_FIN;
                        end
                        `CMD_FIN: begin
                            tagValid_d = 1'b1;
                            tag_d      = T;
                            state_d    = ST_IDLE;
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
`ifdef MGM_SEQ_TIMEOUT_EN
                else if (toCnt_q == 8'd254) begin
                    err_d    = 1'b1;
                    colBuf_d = 64'h0;
                    cnt_d    = 4'd0;
                    blk_d    = 64'h0;
                    blen_d   = 64'h0;
                    state_d  = ST_IDLE;
                end else begin
                    toCnt_d = toCnt_q + 8'd1;
                end
`endif
            end

            default: state_d = ST_IDLE;
        endcase

        if (cmd != `CMD_NONE) begin
            lastCmd_d = cmd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            colBuf_q   <= 64'h0;
            cnt_q      <= 4'd0;
            heldLast_q <= 1'b0;
            fin_q      <= 1'b0;
            lastCmd_q  <= `CMD_NONE;
            blk_q      <= 64'h0;
            blen_q     <= 64'h0;
            issBytes_q <= 4'd0;
            err_q      <= 1'b0;
            cValid_q   <= 1'b0;
            cData_q    <= 64'h0;
            cBytes_q   <= 4'd0;
            tagValid_q <= 1'b0;
            tag_q      <= 64'h0;
            doneD_q    <= 1'b0;
            readyEn_q  <= 1'b0;
`ifdef MGM_SEQ_TIMEOUT_EN
            toCnt_q    <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            colBuf_q   <= colBuf_d;
            cnt_q      <= cnt_d;
            heldLast_q <= heldLast_d;
            fin_q      <= fin_d;
            lastCmd_q  <= lastCmd_d;
            blk_q      <= blk_d;
            blen_q     <= blen_d;
            issBytes_q <= issBytes_d;
            err_q      <= err_d;
            cValid_q   <= cValid_d;
            cData_q    <= cData_d;
            cBytes_q   <= cBytes_d;
            tagValid_q <= tagValid_d;
            tag_q      <= tag_d;
            doneD_q    <= done;
            readyEn_q  <= 1'b1;
`ifdef MGM_SEQ_TIMEOUT_EN
            toCnt_q    <= toCnt_d;
`endif
        end
    end

endmodule

// File: doc/mgm_sequencer.md
MGM_SEQUENCER -- requirements
Module: mgm_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-002 SHALL have ports: s_valid  in  1  byte-stream valid; s_ready  out  1  byte accepted when s_valid&s_ready.
REQ-003 SHALL have ports: s_data  in  8  payload byte; s_type  in  1  0=associated data (A), 1=message (M); s_last  in  1  final byte of current segment.
REQ-004 SHALL have ports: cmd  out  6  mgm command (`CMD_* codes from mgm.vh); blk  out  64  block to mgm A and M; blen  out  64  valid bits in blk, to len_A and len_M.
REQ-005 SHALL have ports: done  in  1  mgm completion; C  in  64  mgm ciphertext; T  in  64  mgm tag.
REQ-006 SHALL have ports: c_valid  out  1  one-cycle ciphertext strobe; c_data  out  64  ciphertext block; c_bytes  out  4  valid bytes 1..8 in c_data.
REQ-007 SHALL have ports: tag_valid  out  1  one-cycle tag strobe; tag  out  64  tag; busy  out  1  frame in progress; err  out  1  sticky protocol/timeout error.

Function
REQ-008 SHALL pack bytes MSB-first: first byte of a block to blk[63:56]; unused low bytes zero; blen = 8*bytes (8..64).
REQ-009 SHALL implement states IDLE, START_A, COL_A, ISS_A, START_M, COL_M, ISS_M, FIN, WAIT.
REQ-010 IDLE: s_ready=1; first accepted byte SHALL have s_type=0, else err=1 and byte dropped; valid A byte -> issue `CMD_START_A, byte held.
REQ-011 COL_A/COL_M: s_ready=1; 8th byte without s_last -> issue `CMD_A / `CMD_DOUBLE_M; byte with s_last (any count 1..8) -> issue `CMD_FIN_A / `CMD_FIN_M.
REQ-012 After `CMD_FIN_A SHALL issue `CMD_START_M, then COL_M; after `CMD_FIN_M SHALL issue `CMD_FIN.
REQ-013 Every command SHALL be driven for exactly one cycle, blk/blen stable from that cycle until done; cmd=`CMD_NONE otherwise.
REQ-014 WAIT: s_ready=0; advance only on rising edge of done (done high while previous sample low); first edge sampled no earlier than cycle after cmd.
REQ-015 On done after `CMD_DOUBLE_M/`CMD_FIN_M: c_valid=1 one cycle, c_data = C with bytes beyond c_bytes zeroed, c_bytes = bytes in that block.
REQ-016 On done after `CMD_FIN: tag_valid=1 one cycle, tag=T, return to IDLE; busy=0 only in IDLE.
REQ-017 s_type mismatch in COL_A/COL_M (M byte before A s_last, A byte after) SHALL set err, drop byte, stay in state.
REQ-018 err SHALL clear only on reset; operation continues after err.
REQ-019 Per-frame: exactly one START_A, one FIN_A, one START_M, one FIN_M, one FIN; empty segments not supported.

Reset
REQ-020 rst_n low SHALL immediately force IDLE, cmd=`CMD_NONE, blk=0, blen=0, c_valid=0, c_data=0, c_bytes=0, tag_valid=0, tag=0, busy=0, err=0, s_ready=0.
REQ-021 s_ready SHALL rise first clock after rst_n deasserts; reset mid-frame discards partial block, no command issued.

Configuration
REQ-022 With MGM_SEQ_TIMEOUT_EN defined: 8-bit counter in WAIT; 255 cycles without done edge -> err=1, cmd=`CMD_NONE, state IDLE, partial frame discarded.
REQ-023 Without MGM_SEQ_TIMEOUT_EN: no counter; WAIT held indefinitely until done edge.

Verification
REQ-024 Key FFEEDDCC..FCFDFEFF, nonce 12DEF06B3C130A59; A=01x8,02x8,03x8,04x8,05x8 bytes + EA(last) -> START_A, 5x`CMD_A, `CMD_FIN_A blk=EA00000000000000 blen=8.
REQ-025 M bytes FFEEDDCCBBAA9988 ... 2233445566778899 (8 blocks) + AA,BB,CC(last) -> START_M, 8x`CMD_DOUBLE_M, `CMD_FIN_M blk=AABBCC0000000000 blen=24, then `CMD_FIN; 9 c_valid (last c_bytes=3), one tag_valid.
REQ-026 A segment exactly 16 bytes -> `CMD_A then `CMD_FIN_A blen=64; no third A command.
REQ-027 M byte while in COL_A -> err=1, byte dropped, subsequent frame completes normally.
REQ-028 rst_n low during WAIT after third `CMD_DOUBLE_M -> all outputs reset values; new frame starts with `CMD_START_A; with MGM_SEQ_TIMEOUT_EN, done held low -> err=1 at 255 cycles, IDLE.
